dc_bank_arbiter: RTL and testbench

//  Shares one DC data bank (ram_1port_fast behind DC_1_databank) between two requesters:
//  the core load/store port (single beat) and the line engine (4-beat fill write or

---
 rtl/dc_bank_arbiter.sv | 227 ++++++++++++++++++++++
 tb/tb_dc_bank_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dc_bank_arbiter.sv
// dc_bank_arbiter: shares one DC data bank between the core load/store port
// (single beat) and the line engine (4-beat fill write or victim read).
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   core_req_* / core_ack_*    core request channel and read-ack channel
//   line_req_* / line_ack_*    line engine beat request channel and victim-read ack channel
//   line_done                  1-cycle pulse, the cycle after the 4th line beat is accepted
//   proto_err                  sticky flag: bank ack arrived with no read outstanding
//   bank_req_* / bank_ack_*    bank request channel and bank read-ack channel
//
// A transfer on any channel is valid & !retry in the same cycle. Grant is made combinationally
// each cycle. A line burst, once beat 0 is accepted, owns the bank until beat 3 is accepted.
// Reads push a source tag into a small route FIFO so read acks go back in issue order.
module dc_bank_arbiter #(
   parameter int unsigned WAY_BITS  = 2,
   parameter int unsigned MAX_OUTST = 4
) (
   input  logic                clk,
   input  logic                reset,
   // core port
   input  logic                core_req_valid,
   output logic                core_req_retry,
   input  logic                core_req_write,
   input  logic [28:0]         core_req_addr,
   input  logic [WAY_BITS-1:0] core_req_way,
   input  logic [1:0]          core_req_row,
   input  logic [35:0]         core_req_data,
   output logic                core_ack_valid,
   input  logic                core_ack_retry,
   output logic [35:0]         core_ack_data,
   // line engine port
   input  logic                line_req_valid,
   output logic                line_req_retry,
   input  logic                line_req_write,
   input  logic [28:0]         line_req_addr,
   input  logic [WAY_BITS-1:0] line_req_way,
   input  logic [35:0]         line_req_data,
   output logic                line_ack_valid,
   input  logic                line_ack_retry,
   output logic [35:0]         line_ack_data,
   output logic                line_done,
   output logic                proto_err,
   // bank port
   output logic                bank_req_valid,
   input  logic                bank_req_retry,
   output logic                bank_req_write,
   output logic [28:0]         bank_req_addr,
   output logic [WAY_BITS-1:0] bank_req_way_no,
   output logic [1:0]          bank_req_row_even_odd,
   output logic [35:0]         bank_req_data,
   input  logic                bank_ack_valid,
   output logic                bank_ack_retry,
   input  logic [35:0]         bank_ack_data
);

   localparam int unsigned PtrW = $clog2(MAX_OUTST);
   localparam int unsigned CntW = PtrW + 1;

   typedef enum logic [0:0] {StIdle, StBurst} state_e;

   state_e              state_q, state_d;
   logic [1:0]          beat_q, beat_d;
   logic                rr_q, rr_d;            // 0: core first, 1: line first
   logic                line_write_q, line_write_d;
   logic                line_done_q, line_done_d;
   logic                proto_err_q, proto_err_d;

   logic [MAX_OUTST-1:0] tag_q;                // 0: core, 1: line
   logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]      count_q;

   logic sel_core, sel_line;
   logic line_write_eff;
   logic sel_read, gate;
   logic core_xfer, line_xfer;
   logic fifo_full, fifo_empty;
   logic push, push_tag, pop;
   logic head_tag;

   assign fifo_full  = (count_q == CntW'(MAX_OUTST));
   assign fifo_empty = (count_q == '0);
   assign head_tag   = tag_q[rd_ptr_q];

   // Fill/victim direction is taken live on beat 0 and from the latch for later beats.
   assign line_write_eff = (state_q == StBurst) ? line_write_q : line_req_write;

   // Requester selection and request mux
   always_comb begin
      sel_core = 1'b0;
      sel_line = 1'b0;
      if (state_q == StBurst) begin
         sel_line = line_req_valid;
      end else if (core_req_valid && line_req_valid) begin
         sel_line = rr_q;
         sel_core = !rr_q;
      end else begin
         sel_core = core_req_valid;
         sel_line = line_req_valid;
      end

      // Reads are blocked on a full route FIFO as of cycle start; a same-cycle pop
      // does not count, which keeps the gate off the ack path.
      sel_read = (sel_core && !core_req_write) || (sel_line && !line_write_eff);
      gate     = sel_read && fifo_full;

      bank_req_valid        = (sel_core || sel_line) && !gate;
      bank_req_write        = 1'b0;
      bank_req_addr         = '0;
      bank_req_way_no       = '0;
      bank_req_row_even_odd = '0;
      bank_req_data         = '0;
      if (sel_line) begin
         bank_req_write        = line_write_eff;
         bank_req_addr         = line_req_addr;
         bank_req_way_no       = line_req_way;
         bank_req_row_even_odd = beat_q;
         bank_req_data         = line_req_data;
      end else if (sel_core) begin
         bank_req_write        = core_req_write;
         bank_req_addr         = core_req_addr;
         bank_req_way_no       = core_req_way;
         bank_req_row_even_odd = core_req_row;
         bank_req_data         = core_req_data;
      end

      core_xfer      = sel_core && bank_req_valid && !bank_req_retry;
      line_xfer      = sel_line && bank_req_valid && !bank_req_retry;
      core_req_retry = !core_xfer;
      line_req_retry = !line_xfer;

      push     = (core_xfer && !core_req_write) || (line_xfer && !line_write_eff);
      push_tag = line_xfer;
   end

   // Ack routing from FIFO head; an ack with nothing outstanding is swallowed.
   always_comb begin
      core_ack_valid = bank_ack_valid && !fifo_empty && !head_tag;
      line_ack_valid = bank_ack_valid && !fifo_empty && head_tag;
      core_ack_data  = bank_ack_data;
      line_ack_data  = bank_ack_data;
      bank_ack_retry = fifo_empty ? 1'b0 : (head_tag ? line_ack_retry : core_ack_retry);
      pop            = bank_ack_valid && !fifo_empty && !bank_ack_retry;
      proto_err_d    = proto_err_q || (bank_ack_valid && fifo_empty);
   end

   // Burst FSM
   always_comb begin
      state_d      = state_q;
      beat_d       = beat_q;
      rr_d         = rr_q;
      line_write_d = line_write_q;
      line_done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (line_xfer) begin
               state_d      = StBurst;
               beat_d       = 2'd1;
               line_write_d = line_req_write;
            end else if (core_xfer) begin
               rr_d = 1'b1;
            end
         end
         StBurst: begin
            if (line_xfer) begin
               if (beat_q == 2'd3) begin
                  state_d     = StIdle;
                  beat_d      = 2'd0;
                  line_done_d = 1'b1;
                  rr_d        = 1'b0;
               end else begin
                  beat_d = beat_q + 2'd1;
               end
            end
         end
         default: begin
            state_d = StIdle;
            beat_d  = 2'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= StIdle;
         beat_q       <= 2'd0;
         rr_q         <= 1'b0;
         line_write_q <= 1'b0;
         line_done_q  <= 1'b0;
         proto_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         beat_q       <= beat_d;
         rr_q         <= rr_d;
         line_write_q <= line_write_d;
         line_done_q  <= line_done_d;
         proto_err_q  <= proto_err_d;
      end
   end

   // Route FIFO; pointers wrap naturally since MAX_OUTST is a power of 2.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tag_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            tag_q[wr_ptr_q] <= push_tag;
            wr_ptr_q        <= wr_ptr_q + PtrW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end
         if (push && !pop) begin
            count_q <= count_q + CntW'(1);
         end else if (pop && !push) begin
            count_q <= count_q - CntW'(1);
         end
      end
   end

   assign line_done = line_done_q;
   assign proto_err = proto_err_q;

endmodule

// File: tb/tb_dc_bank_arbiter.sv
module tb_dc_bank_arbiter;

   localparam int unsigned WB = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          core_req_valid, core_req_retry, core_req_write;
   logic [28:0]   core_req_addr;
   logic [WB-1:0] core_req_way;
   logic [1:0]    core_req_row;
   logic [35:0]   core_req_data;
   logic          core_ack_valid, core_ack_retry;
   logic [35:0]   core_ack_data;
   logic          line_req_valid, line_req_retry, line_req_write;
   logic [28:0]   line_req_addr;
   logic [WB-1:0] line_req_way;
   logic [35:0]   line_req_data;
   logic          line_ack_valid, line_ack_retry;
   logic [35:0]   line_ack_data;
   logic          line_done, proto_err;
   logic          bank_req_valid, bank_req_retry, bank_req_write;
   logic [28:0]   bank_req_addr;
   logic [WB-1:0] bank_req_way_no;
   logic [1:0]    bank_req_row_even_odd;
   logic [35:0]   bank_req_data;
   logic          bank_ack_valid, bank_ack_retry;
   logic [35:0]   bank_ack_data;

   int n_cmp = 0;
   int n_err = 0;
   logic sb_q[$];   // expected ack destination per issued read: 0 core, 1 line

   always #5 clk = ~clk;

   dc_bank_arbiter #(.WAY_BITS(WB), .MAX_OUTST(4)) dut (
      .clk(clk), .reset(reset),
      .core_req_valid(core_req_valid), .core_req_retry(core_req_retry),
      .core_req_write(core_req_write), .core_req_addr(core_req_addr),
      .core_req_way(core_req_way), .core_req_row(core_req_row),
      .core_req_data(core_req_data), .core_ack_valid(core_ack_valid),
      .core_ack_retry(core_ack_retry), .core_ack_data(core_ack_data),
      .line_req_valid(line_req_valid), .line_req_retry(line_req_retry),
      .line_req_write(line_req_write), .line_req_addr(line_req_addr),
      .line_req_way(line_req_way), .line_req_data(line_req_data),
      .line_ack_valid(line_ack_valid), .line_ack_retry(line_ack_retry),
      .line_ack_data(line_ack_data), .line_done(line_done), .proto_err(proto_err),
      .bank_req_valid(bank_req_valid), .bank_req_retry(bank_req_retry),
      .bank_req_write(bank_req_write), .bank_req_addr(bank_req_addr),
      .bank_req_way_no(bank_req_way_no), .bank_req_row_even_odd(bank_req_row_even_odd),
      .bank_req_data(bank_req_data), .bank_ack_valid(bank_ack_valid),
      .bank_ack_retry(bank_ack_retry), .bank_ack_data(bank_ack_data)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   // Compare the currently presented bank ack against the scoreboard head.
   task automatic ack_expect(input string tag);
      logic dest;
      chk({tag, "_sb_nonempty"}, 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
         dest = sb_q.pop_front();
         chk({tag, "_core_vld"}, 64'(core_ack_valid), 64'(!dest));
         chk({tag, "_line_vld"}, 64'(line_ack_valid), 64'(dest));
         chk({tag, "_data"}, 64'(dest ? line_ack_data : core_ack_data), 64'(bank_ack_data));
         chk({tag, "_no_stall"}, 64'(bank_ack_retry), 64'd0);
      end
   endtask

   task automatic ack_beat(input string tag, input logic [35:0] d);
      bank_ack_valid = 1'b1;
      bank_ack_data  = d;
      settle();
      ack_expect(tag);
      tick();
      bank_ack_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      core_req_valid = 0; core_req_write = 0; core_req_addr = '0; core_req_way = '0;
      core_req_row = '0; core_req_data = '0; core_ack_retry = 0;
      line_req_valid = 0; line_req_write = 0; line_req_addr = '0; line_req_way = '0;
      line_req_data = '0; line_ack_retry = 0;
      bank_req_retry = 0; bank_ack_valid = 0; bank_ack_data = '0;

      // Reset state
      repeat (2) tick();
      chk("rst_core_retry", 64'(core_req_retry), 64'd1);
      chk("rst_line_retry", 64'(line_req_retry), 64'd1);
      chk("rst_bank_valid", 64'(bank_req_valid), 64'd0);
      chk("rst_line_done", 64'(line_done), 64'd0);
      chk("rst_proto_err", 64'(proto_err), 64'd0);
      chk("rst_bank_ack_retry", 64'(bank_ack_retry), 64'd0);
      reset = 1'b1;
      tick();

      // Core write passes straight through to the bank
      core_req_valid = 1; core_req_write = 1; core_req_addr = 29'h40;
      core_req_way = 2'd1; core_req_row = 2'd2; core_req_data = 36'h5_1234_5678;
      settle();
      chk("cw_bank_valid", 64'(bank_req_valid), 64'd1);
      chk("cw_bank_write", 64'(bank_req_write), 64'd1);
      chk("cw_addr", 64'(bank_req_addr), 64'h40);
      chk("cw_way", 64'(bank_req_way_no), 64'd1);
      chk("cw_row", 64'(bank_req_row_even_odd), 64'd2);
      chk("cw_data", 64'(bank_req_data), 64'h5_1234_5678);
      chk("cw_retry", 64'(core_req_retry), 64'd0);
      tick();
      core_req_valid = 0;

      // From reset, core wins a tie, then the fill burst runs back-to-back
      reset = 1'b0; #1; reset = 1'b1;
      core_req_valid = 1; core_req_write = 1; core_req_row = 2'd1;
      line_req_valid = 1; line_req_write = 1; line_req_addr = 29'h1000;
      line_req_way = 2'd3; line_req_data = 36'hA_0000_0000;
      settle();
      chk("tie_core_retry", 64'(core_req_retry), 64'd0);
      chk("tie_line_retry", 64'(line_req_retry), 64'd1);
      chk("tie_row_core", 64'(bank_req_row_even_odd), 64'd1);
      tick();
      core_req_valid = 0;
      settle();
      chk("fill_b0_retry", 64'(line_req_retry), 64'd0);
      chk("fill_b0_row", 64'(bank_req_row_even_odd), 64'd0);
      chk("fill_b0_way", 64'(bank_req_way_no), 64'd3);
      tick();
      core_req_valid = 1;
      line_req_write = 0;   // direction must stay latched from beat 0
      for (int b = 1; b < 4; b++) begin
         line_req_data = 36'hA_0000_0000 + 36'(b);
         settle();
         chk("fill_row", 64'(bank_req_row_even_odd), 64'(b));
         chk("fill_line_retry", 64'(line_req_retry), 64'd0);
         chk("fill_core_retry", 64'(core_req_retry), 64'd1);
         chk("fill_write_held", 64'(bank_req_write), 64'd1);
         chk("fill_data", 64'(bank_req_data), 64'(36'hA_0000_0000 + 36'(b)));
         chk("fill_no_done", 64'(line_done), 64'd0);
         tick();
      end
      line_req_valid = 0;
      settle();
      chk("fill_done", 64'(line_done), 64'd1);
      chk("post_burst_core", 64'(core_req_retry), 64'd0);
      tick();
      core_req_valid = 0;
      settle();
      chk("done_pulse_end", 64'(line_done), 64'd0);

      // Four reads fill the route FIFO; the fifth waits for a pop
      core_req_write = 0;
      core_req_valid = 1;
      for (int i = 0; i < 4; i++) begin
         core_req_addr = 29'(32'h200 + 32'(i));
         settle();
         chk("rd_accept", 64'(core_req_retry), 64'd0);
         sb_q.push_back(1'b0);
         tick();
      end
      core_req_addr = 29'h300;
      settle();
      chk("rd5_held", 64'(core_req_retry), 64'd1);
      chk("rd5_no_bank", 64'(bank_req_valid), 64'd0);
      tick();
      bank_ack_valid = 1; bank_ack_data = 36'h1_1111_1111;
      settle();
      ack_expect("ack0");
      chk("rd5_pop_no_unblock", 64'(core_req_retry), 64'd1);
      tick();
      bank_ack_valid = 0;
      settle();
      chk("rd5_accept", 64'(core_req_retry), 64'd0);
      sb_q.push_back(1'b0);
      tick();
      core_req_valid = 0;
      for (int i = 0; i < 4; i++) ack_beat("drain_a", 36'(32'h2000 + 32'(i)));

      // Core read, victim burst, core read: acks route in issue order
      core_req_valid = 1; core_req_addr = 29'h400;
      settle();
      chk("ic_rd1", 64'(core_req_retry), 64'd0);
      sb_q.push_back(1'b0);
      tick();
      core_req_valid = 0;
      line_req_valid = 1; line_req_write = 0; line_req_addr = 29'h2000;
      for (int b = 0; b < 3; b++) begin
         settle();
         chk("vic_accept", 64'(line_req_retry), 64'd0);
         chk("vic_row", 64'(bank_req_row_even_odd), 64'(b));
         chk("vic_is_read", 64'(bank_req_write), 64'd0);
         sb_q.push_back(1'b1);
         tick();
      end
      bank_ack_valid = 1; bank_ack_data = 36'h3_0000_0001; core_ack_retry = 1;
      settle();
      chk("vic_b3_gated", 64'(line_req_retry), 64'd1);
      chk("vic_b3_no_bank", 64'(bank_req_valid), 64'd0);
      chk("stall_core_vld", 64'(core_ack_valid), 64'd1);
      chk("stall_bank_retry", 64'(bank_ack_retry), 64'd1);
      tick();
      core_ack_retry = 0;
      settle();
      ack_expect("ack_ic1");
      chk("vic_b3_still_gated", 64'(line_req_retry), 64'd1);
      tick();
      bank_ack_valid = 0;
      settle();
      chk("vic_b3_accept", 64'(line_req_retry), 64'd0);
      chk("vic_b3_row", 64'(bank_req_row_even_odd), 64'd3);
      sb_q.push_back(1'b1);
      tick();
      line_req_valid = 0;
      bank_ack_valid = 1; bank_ack_data = 36'h3_0000_0002; core_ack_retry = 1;
      settle();
      chk("vic_done", 64'(line_done), 64'd1);
      ack_expect("ack_line_core_stalled");
      tick();
      bank_ack_valid = 0; core_ack_retry = 0;
      core_req_valid = 1; core_req_addr = 29'h404;
      settle();
      chk("ic_rd2", 64'(core_req_retry), 64'd0);
      sb_q.push_back(1'b0);
      tick();
      core_req_valid = 0;
      for (int i = 0; i < 4; i++) ack_beat("drain_b", 36'(32'h4000 + 32'(i)));

      // Bank back-pressure on fill beat 2 holds the beat
      line_req_valid = 1; line_req_write = 1; line_req_addr = 29'h3000;
      tick(); tick();
      bank_req_retry = 1;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("bp_row", 64'(bank_req_row_even_odd), 64'd2);
         chk("bp_line_retry", 64'(line_req_retry), 64'd1);
         chk("bp_valid", 64'(bank_req_valid), 64'd1);
         tick();
      end
      bank_req_retry = 0;
      settle();
      chk("bp_release_row", 64'(bank_req_row_even_odd), 64'd2);
      chk("bp_release_accept", 64'(line_req_retry), 64'd0);
      tick();
      settle();
      chk("bp_b3_row", 64'(bank_req_row_even_odd), 64'd3);
      tick();
      line_req_valid = 0;
      settle();
      chk("bp_done", 64'(line_done), 64'd1);

      // Stray bank ack with nothing outstanding
      bank_ack_valid = 1; bank_ack_data = 36'hF_FFFF_FFFF;
      settle();
      chk("stray_core_vld", 64'(core_ack_valid), 64'd0);
      chk("stray_line_vld", 64'(line_ack_valid), 64'd0);
      chk("stray_retry", 64'(bank_ack_retry), 64'd0);
      tick();
      bank_ack_valid = 0;
      settle();
      chk("proto_err_set", 64'(proto_err), 64'd1);
      tick(); tick();
      chk("proto_err_sticky", 64'(proto_err), 64'd1);

      // Reset in the middle of a victim burst
      line_req_valid = 1; line_req_write = 0; line_req_addr = 29'h5000;
      tick(); tick();
      bank_ack_valid = 1; line_ack_retry = 1; core_ack_retry = 1;
      settle();
      chk("mid_row2", 64'(bank_req_row_even_odd), 64'd2);
      chk("mid_line_ack", 64'(line_ack_valid), 64'd1);
      reset = 1'b0;
      #1;
      chk("mid_rst_row", 64'(bank_req_row_even_odd), 64'd0);
      chk("mid_rst_fifo_empty", 64'(line_ack_valid), 64'd0);
      chk("mid_rst_ack_retry", 64'(bank_ack_retry), 64'd0);
      chk("mid_rst_proto_err", 64'(proto_err), 64'd0);
      bank_ack_valid = 0; line_req_valid = 0; line_ack_retry = 0; core_ack_retry = 0;
      #1;
      reset = 1'b1;
      tick();
      chk("after_rst_core_retry", 64'(core_req_retry), 64'd1);
      chk("after_rst_proto_err", 64'(proto_err), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
